// File: rtl/gap_pkg.sv
// -----------------------------------------------------------------------------
// gap_pkg
// Shared types and helpers for the global-average-pooling channel scheduler.
//   state_e  : scheduler FSM states
//   mult_inv : default reciprocal multiplier 1/INPUT_SIZE in Qm.n format
// -----------------------------------------------------------------------------
package gap_pkg;

  typedef enum logic [1:0] {
    eIDLE   = 2'd0,
    eSERIAL = 2'd1,
    eDONE   = 2'd2
  } state_e;

  // 1/input_size with n_size fractional bits, truncated toward zero.
  function automatic int mult_inv(input int input_size, input int n_size);
    return (1 << n_size) / input_size;
  endfunction

endpackage

// File: rtl/gap_mac_unit.sv
// -----------------------------------------------------------------------------
// gap_mac_unit
// Combinational shared datapath: one multiply by the reciprocal constant, one
// saturating accumulate and one saturating truncation back to a word.
// Optional build macro: GAP_SCHED_OVF_FLAG_EN adds the add_ovf/trunc_ovf
// outputs (saturation indicators); without it the datapath still saturates.
// Ports:
//   x         in   WORD_SIZE    sample of the channel being processed
//   mult      in   WORD_SIZE    reciprocal constant
//   acc       in   2*WORD_SIZE  current accumulator of that channel
//   first     in   1            first sample of the window: acc is replaced
//   acc_next  out  2*WORD_SIZE  new accumulator value
//   word      out  WORD_SIZE    acc_next >>> N_SIZE saturated to a word
//   add_ovf   out  1            accumulate saturated   (macro only)
//   trunc_ovf out  1            truncation saturated   (macro only)
// -----------------------------------------------------------------------------
module gap_mac_unit #(
  parameter int WORD_SIZE = 16,
  parameter int N_SIZE    = 12
) (
  input  logic signed [WORD_SIZE-1:0]   x,
  input  logic signed [WORD_SIZE-1:0]   mult,
  input  logic signed [2*WORD_SIZE-1:0] acc,
  input  logic                          first,
  output logic signed [2*WORD_SIZE-1:0] acc_next,
  output logic signed [WORD_SIZE-1:0]   word
`ifdef GAP_SCHED_OVF_FLAG_EN
  ,
  output logic                          add_ovf,
  output logic                          trunc_ovf
`endif
);

  localparam int AW = 2 * WORD_SIZE;
  localparam logic signed [AW-1:0]        ACC_MAX  = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0]        ACC_MIN  = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [WORD_SIZE-1:0] WORD_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [WORD_SIZE-1:0] WORD_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};

  // One extra bit of headroom; overflow shows as the top two bits disagreeing.
  function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b);
    logic [AW:0] s;
    s = {a[AW-1], a} + {b[AW-1], b};
    if (s[AW] != s[AW-1]) return s[AW] ? ACC_MIN : ACC_MAX;
    return s[AW-1:0];
  endfunction

  // The shifted value fits a word only if all bits above the word sign agree.
  function automatic logic signed [WORD_SIZE-1:0] trunc_sat(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] sh;
    sh = v >>> N_SIZE;
    if (sh[AW-1:WORD_SIZE-1] != {(AW-WORD_SIZE+1){sh[AW-1]}})
      return sh[AW-1] ? WORD_MIN : WORD_MAX;
    return sh[WORD_SIZE-1:0];
  endfunction

`ifdef GAP_SCHED_OVF_FLAG_EN
  function automatic logic add_hit(input logic signed [AW-1:0] a,
                                   input logic signed [AW-1:0] b);
    logic [AW:0] s;
    s = {a[AW-1], a} + {b[AW-1], b};
    return s[AW] ^ s[AW-1];
  endfunction

  function automatic logic trunc_hit(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] sh;
    sh = v >>> N_SIZE;
    return sh[AW-1:WORD_SIZE-1] != {(AW-WORD_SIZE+1){sh[AW-1]}};
  endfunction
`endif

  logic signed [AW-1:0] prod;

  // Full-width signed product cannot overflow 2*WORD_SIZE bits.
  assign prod     = $signed({{WORD_SIZE{x[WORD_SIZE-1]}}, x}) *
                    $signed({{WORD_SIZE{mult[WORD_SIZE-1]}}, mult});
  assign acc_next = first ? prod : sat_add(acc, prod);
  assign word     = trunc_sat(acc_next);

`ifdef GAP_SCHED_OVF_FLAG_EN
  assign add_ovf   = !first && add_hit(acc, prod);
  assign trunc_ovf = trunc_hit(acc_next);
`endif

endmodule

// File: rtl/gap_channel_scheduler.sv
// -----------------------------------------------------------------------------
// gap_channel_scheduler
// Global average pooling over INPUT_SIZE vectors of NUM_CHANNELS words, using a
// single shared multiply/saturating-accumulate unit that visits one channel per
// cycle. Each accepted vector costs 1 accept cycle + NUM_CHANNELS serial cycles.
// Optional build macro: GAP_SCHED_OVF_FLAG_EN adds the sticky ovf_o output.
// Ports:
//   clk_i     in   1                       clock
//   reset_i   in   1                       synchronous active-high reset
//   ready_o   out  1                       idle, can accept a vector
//   valid_i   in   1                       input vector valid
//   data_r_i  in   NUM_CHANNELS*WORD_SIZE  input vector, channel c at word c
//   valid_o   out  1                       averaged vector valid
//   ready_i   in   1                       downstream ready
//   data_r_o  out  NUM_CHANNELS*WORD_SIZE  averaged vector, same packing
//   ovf_o     out  1                       saturation seen this window (macro)
// -----------------------------------------------------------------------------
module gap_channel_scheduler
  import gap_pkg::*;
#(
  parameter int INPUT_SIZE   = 4,
  parameter int WORD_SIZE    = 16,
  parameter int N_SIZE       = 12,
  parameter int NUM_CHANNELS = 3,
  parameter logic signed [WORD_SIZE-1:0] MULTIPLIER = WORD_SIZE'(mult_inv(INPUT_SIZE, N_SIZE))
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  output logic                              ready_o,
  input  logic                              valid_i,
  input  logic [NUM_CHANNELS*WORD_SIZE-1:0] data_r_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [NUM_CHANNELS*WORD_SIZE-1:0] data_r_o
`ifdef GAP_SCHED_OVF_FLAG_EN
  ,
  output logic                              ovf_o
`endif
);

  localparam int AW = 2 * WORD_SIZE;
  localparam int SW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(INPUT_SIZE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NUM_CHANNELS - 1);

  state_e                      state;
  logic [SW-1:0]               sample_cnt;
  logic [CW-1:0]               ch_cnt;
  logic signed [WORD_SIZE-1:0] in_reg [NUM_CHANNELS];
  logic signed [AW-1:0]        acc    [NUM_CHANNELS];
  logic signed [WORD_SIZE-1:0] avg    [NUM_CHANNELS];

  logic signed [AW-1:0]        acc_next;
  logic signed [WORD_SIZE-1:0] word;
  logic                        first;
  logic                        last_sample;

  assign first       = (sample_cnt == '0);
  assign last_sample = (sample_cnt == S_LAST);

`ifdef GAP_SCHED_OVF_FLAG_EN
  logic add_ovf;
  logic trunc_ovf;
  logic sat_hit;
  // Truncation only matters on the final sample, when the result is produced.
  assign sat_hit = add_ovf | (last_sample & trunc_ovf);
`endif

  gap_mac_unit #(
    .WORD_SIZE (WORD_SIZE),
    .N_SIZE    (N_SIZE)
  ) u_mac (
    .x         (in_reg[ch_cnt]),
    .mult      (MULTIPLIER),
    .acc       (acc[ch_cnt]),
    .first     (first),
    .acc_next  (acc_next),
    .word      (word)
`ifdef GAP_SCHED_OVF_FLAG_EN
    ,
    .add_ovf   (add_ovf),
    .trunc_ovf (trunc_ovf)
`endif
  );

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_out
    assign data_r_o[c*WORD_SIZE +: WORD_SIZE] = avg[c];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= eIDLE;
      ready_o    <= 1'b1;
      valid_o    <= 1'b0;
      sample_cnt <= '0;
      ch_cnt     <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        acc[c] <= '0;
        avg[c] <= '0;
      end
`ifdef GAP_SCHED_OVF_FLAG_EN
      ovf_o      <= 1'b0;
`endif
    end else begin
      unique case (state)
        eIDLE: begin
          if (valid_i) begin
            for (int c = 0; c < NUM_CHANNELS; c++)
              in_reg[c] <= data_r_i[c*WORD_SIZE +: WORD_SIZE];
            ch_cnt  <= '0;
            state   <= eSERIAL;
            ready_o <= 1'b0;
          end
        end
        eSERIAL: begin
          acc[ch_cnt] <= acc_next;
          // Only the final sample's result is published, so avg holds the
          // previous window's result until this window completes.
          if (last_sample) avg[ch_cnt] <= word;
`ifdef GAP_SCHED_OVF_FLAG_EN
          if (first && ch_cnt == '0) ovf_o <= sat_hit;
          else                       ovf_o <= ovf_o | sat_hit;
`endif
          if (ch_cnt == C_LAST) begin
            ch_cnt <= '0;
            if (last_sample) begin
              sample_cnt <= '0;
              state      <= eDONE;
              valid_o    <= 1'b1;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
              state      <= eIDLE;
              ready_o    <= 1'b1;
            end
          end else begin
            ch_cnt <= ch_cnt + 1'b1;
          end
        end
        eDONE: begin
          if (ready_i) begin
            state   <= eIDLE;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state   <= eIDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
